linebuffer_ctrl: RTL
====================

Name: linebuffer_ctrl

Overview:
- Frame-level sequencer that drives one `linebuffer` instance (DATA_LINES rows × IMG_W pixels) for a 2D window filter such as a 3x3 Gaussian.
- Accepts a raster pixel stream with vsync/de and generates the linebuffer write strobe, read strobe and write data.
- Tracks window-centre coordinates and image-border flags for the downstream kernel.
- After the last input row, injects zero-padded flush rows so that every input pixel produces exactly one window.

Parameters:
- IMG_W, 1024, active pixels per line; must equal the linebuffer DATA_NUM.
- IMG_H, 768, active lines per frame.
- DATA_LINES, 3, window height; odd, ≥3; must equal the linebuffer DATA_LINES.
- DATA_WIDTH, 8, pixel width.
- Derived: HALF = DATA_LINES/2; XW = $clog2(IMG_W); YW = $clog2(IMG_H).

Ports:
- clk  in  1  Single clock; also wired to linebuffer in_clk and out_clk.
- rst  in  1  Asynchronous, active-high reset.
- in_vsync  in  1  Frame start; a rising edge starts a frame.
- in_de  in  1  Input pixel valid.
- in_data  in  DATA_WIDTH  Input pixel.
- lb_in_de  out  1  To linebuffer in_de.
- lb_in_data  out  DATA_WIDTH  To linebuffer in_data.
- lb_out_de  out  1  To linebuffer out_de.
- win_valid  out  1  Linebuffer out_data holds a valid column this cycle.
- win_x  out  XW  Window-centre column.
- win_y  out  YW  Window-centre row.
- win_left, win_right, win_top, win_bot  out  1 each  Border flags.
- frame_done  out  1  One-cycle pulse after the last window of a frame.
- frame_err  out  1  One-cycle pulse on an aborted frame.
- drop  out  1  One-cycle pulse when an input pixel is discarded.

Behaviour:
- Reset: state=IDLE; all counters 0; every output 0.
- in_vsync is registered once; rising edge = vs_q & ~vs_q2.
- States:
  - IDLE: in_de pixels are dropped (drop=1). Vsync rise → FILL; in_x, in_y, out_x, out_y cleared.
  - FILL: each in_de pixel → lb_in_de=1, lb_in_data=in_data (registered, 1-cycle latency). in_x wraps at IMG_W-1 and in_y then increments. When in_y reaches HALF → RUN.
  - RUN: same write path. Additionally lb_out_de = lb_in_de delayed 1 cycle. Write of the last pixel of row IMG_H-1 → FLUSH, with flush counters cleared.
  - FLUSH: emits HALF×IMG_W writes on consecutive cycles with lb_in_data=0, followed by the same read path. Real in_de pixels are dropped (drop=1). After the final flush write → DONE.
  - DONE: waits for the pipeline to drain (2 cycles), pulses frame_done → IDLE.
- Window timing:
  - win_valid = lb_out_de delayed 1 cycle, aligned with the registered linebuffer out_data.
  - win_x/win_y come from an out counter advanced on each win_valid: out_x wraps at IMG_W-1, then out_y increments.
  - Exactly IMG_W×IMG_H win_valid pulses per frame; the last has win_x=IMG_W-1, win_y=IMG_H-1.
- Border flags are valid only with win_valid, 0 otherwise:
  - win_left = (win_x==0)
  - win_right = (win_x==IMG_W-1)
  - win_top = (win_y<HALF)
  - win_bot = (win_y>IMG_H-1-HALF)
- Boundary conditions:
  - Vsync rise in FILL/RUN/FLUSH/DONE: frame_err pulse; state → FILL with counters cleared. The pixel on that cycle is treated as the first pixel of the new frame. In-flight win_valid still completes (≤2 cycles).
  - Extra in_de pixels after row IMG_H-1 in RUN: this case cannot occur, since the state leaves RUN on the last pixel.
  - in_de gaps: all counters hold; lb strobes are 0.
  - Async reset mid-frame: immediate return to IDLE; outputs 0 the same instant.
  - Linebuffer contents are not cleared; top rows of a frame window contain stale data, and win_top flags them.

Decomposition:
- Package linebuffer_pkg: state enum lbc_state_t {IDLE,FILL,RUN,FLUSH,DONE}, localparam function half_of(lines).
- One sub-module, raster_cnt (parameterised W, H; inc, clr → x, y, last_px, last_row). Instantiated twice: once for input/flush and once for output coordinates.

Test Plan:
- Nominal, config IMG_W=8, IMG_H=4, DATA_LINES=3: vsync then 32 contiguous pixels 0..31 → FILL 8 cycles; 32 win_valid; first window (x0,y0,top,left); last window (x7,y3,bot,right); linebuffer centre row at window (x0,y0) = 0; frame_done once.
- Gapped input, in_de toggling 1/0 every cycle: same 32 windows with identical coordinates; lb_in_de never set during gaps.
- Flush: after the last input pixel, 8 consecutive lb_in_de with data 0; windows for y=3 are produced with no input activity; drop pulses for any in_de during FLUSH.
- Abort: vsync rise after 13 pixels → frame_err pulse; state FILL; the next 32 pixels yield a complete, correctly numbered frame.
- Reset mid-RUN (assert rst for 1 cycle at pixel 20) → all outputs 0 immediately; pixels without vsync are dropped; vsync restarts a clean frame.
- Pixels in IDLE before any vsync: 5 in_de → 5 drop pulses; lb_in_de stays 0.

Source files
------------

// File: rtl/linebuffer_ctrl_pkg.sv
// linebuffer_pkg: shared types and helpers for the line-buffer frame sequencer.
//   lbc_state_t : sequencer state (IDLE, FILL, RUN, FLUSH, DONE)
//   half_of()   : number of rows above or below the window centre
package linebuffer_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FILL  = 3'd1,
    RUN   = 3'd2,
    FLUSH = 3'd3,
    DONE  = 3'd4
  } lbc_state_t;

  function automatic int half_of(input int lines);
    return lines / 2;
  endfunction

endpackage

// File: rtl/linebuffer_ctrl_if.sv
// linebuffer_ctrl_if: pixel-stream input, linebuffer strobes and window outputs.
//   slave  : the sequencer (consumes the pixel stream, produces everything else)
//   master : the pixel source / observer
// Handshake: in_de qualifies in_data on every clock where it is high. There
// is no backpressure. Every pixel is either written to the linebuffer or
// reported through a one-cycle drop pulse. lb_in_de, lb_out_de and win_valid
// are single-cycle strobes. The data they qualify is valid only while the
// strobe is high.
interface linebuffer_ctrl_if #(
  parameter int DATA_WIDTH = 8,
  parameter int XW         = 10,
  parameter int YW         = 10
);
  import linebuffer_pkg::*;

  logic                  in_vsync;
  logic                  in_de;
  logic [DATA_WIDTH-1:0] in_data;
  logic                  lb_in_de;
  logic [DATA_WIDTH-1:0] lb_in_data;
  logic                  lb_out_de;
  logic                  win_valid;
  logic [XW-1:0]         win_x;
  logic [YW-1:0]         win_y;
  logic                  win_left;
  logic                  win_right;
  logic                  win_top;
  logic                  win_bot;
  logic                  frame_done;
  logic                  frame_err;
  logic                  drop;
  lbc_state_t            dbg_state;     // current sequencer state
  logic                  dbg_out_last;  // output counter sits on the final window

  modport slave (
    input  in_vsync, in_de, in_data,
    output lb_in_de, lb_in_data, lb_out_de, win_valid, win_x, win_y,
           win_left, win_right, win_top, win_bot, frame_done, frame_err,
           drop, dbg_state, dbg_out_last
  );

  modport master (
    output in_vsync, in_de, in_data,
    input  lb_in_de, lb_in_data, lb_out_de, win_valid, win_x, win_y,
           win_left, win_right, win_top, win_bot, frame_done, frame_err,
           drop, dbg_state, dbg_out_last
  );
endinterface

// File: rtl/linebuffer_ctrl_raster_cnt.sv
// raster_cnt: raster-order (x, y) counter.
//   i_inc      : advance one pixel (x wraps at W-1, then y advances, y wraps at H-1)
//   i_clr      : restart at (0,0); if i_inc is also high, land on (1,0)
//   o_x, o_y   : current position
//   o_last_px  : x == W-1
//   o_last_row : y == H-1
module raster_cnt #(
  parameter int W  = 1024,
  parameter int H  = 768,
  parameter int XW = $clog2(W),
  parameter int YW = $clog2(H)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_inc,
  input  logic          i_clr,
  output logic [XW-1:0] o_x,
  output logic [YW-1:0] o_y,
  output logic          o_last_px,
  output logic          o_last_row
);
  localparam logic [XW-1:0] X_LAST = XW'(W - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(H - 1);

  logic [XW-1:0] r_x;
  logic [YW-1:0] r_y;

  assign o_x        = r_x;
  assign o_y        = r_y;
  assign o_last_px  = (r_x == X_LAST);
  assign o_last_row = (r_y == Y_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_x <= '0;
      r_y <= '0;
    end else if (i_clr) begin
      // A pixel arriving with the clear is pixel 0 of the new raster.
      r_x <= XW'(i_inc);
      r_y <= '0;
    end else if (i_inc) begin
      if (o_last_px) begin
        r_x <= '0;
        r_y <= o_last_row ? '0 : r_y + 1'b1;
      end else begin
        r_x <= r_x + 1'b1;
      end
    end
  end
endmodule

// File: rtl/linebuffer_ctrl.sv
// linebuffer_ctrl: frame sequencer for one linebuffer (DATA_LINES x IMG_W).
//   clk, rst : single clock, asynchronous active-high reset
//   bus      : linebuffer_ctrl_if.slave
//     in_vsync/in_de/in_data           raster pixel input
//     lb_in_de/lb_in_data/lb_out_de    linebuffer write strobe, data, read strobe
//     win_valid/win_x/win_y/win_*      window-centre coordinates and border flags
//     frame_done/frame_err/drop        one-cycle status pulses
//     dbg_state/dbg_out_last           debug visibility
// The first HALF rows only fill the buffer. Each later write is followed
// one cycle after by a read. After the last input row, HALF zero rows are
// written so that every input pixel produces exactly one window.
module linebuffer_ctrl
  import linebuffer_pkg::*;
#(
  parameter int IMG_W      = 1024,
  parameter int IMG_H      = 768,
  parameter int DATA_LINES = 3,
  parameter int DATA_WIDTH = 8
) (
  input logic              clk,
  input logic              rst,
  linebuffer_ctrl_if.slave bus
);
  localparam int HALF = half_of(DATA_LINES);
  localparam int XW   = $clog2(IMG_W);
  localparam int YW   = $clog2(IMG_H);
  localparam logic [YW-1:0] Y_FILL_LAST = YW'(HALF - 1);
  localparam logic [YW-1:0] Y_TOP       = YW'(HALF);
  localparam logic [YW-1:0] Y_BOT       = YW'(IMG_H - 1 - HALF);

  lbc_state_t            r_state, w_nxt;
  logic                  r_vs_q, r_vs_q2;
  logic [1:0]            r_done_cnt;
  logic                  r_lb_in_de, r_rd_arm, r_lb_out_de;
  logic [DATA_WIDTH-1:0] r_lb_in_data;
  logic                  r_win_valid, r_win_left, r_win_right, r_win_top, r_win_bot;
  logic [XW-1:0]         r_win_x;
  logic [YW-1:0]         r_win_y;
  logic                  r_frame_done, r_frame_err, r_drop;

  logic [XW-1:0]         w_in_x, w_out_x;
  logic [YW-1:0]         w_in_y, w_out_y;
  logic                  w_in_last_px, w_in_last_row, w_out_last_px, w_out_last_row;
  logic                  w_rise, w_abort, w_accept, w_flush_wr, w_wr, w_arm, w_drop;
  logic                  w_fill_to_run, w_run_to_flush, w_flush_end, w_done_pulse;
  logic                  w_in_inc, w_in_clr, w_out_clr;
  logic [DATA_WIDTH-1:0] w_wr_data;

  // Input pixels and flush rows share one counter; flush only needs HALF rows.
  raster_cnt #(.W(IMG_W), .H(IMG_H), .XW(XW), .YW(YW)) u_in_cnt (
    .clk(clk), .rst(rst), .i_inc(w_in_inc), .i_clr(w_in_clr),
    .o_x(w_in_x), .o_y(w_in_y), .o_last_px(w_in_last_px), .o_last_row(w_in_last_row)
  );

  raster_cnt #(.W(IMG_W), .H(IMG_H), .XW(XW), .YW(YW)) u_out_cnt (
    .clk(clk), .rst(rst), .i_inc(r_lb_out_de), .i_clr(w_out_clr),
    .o_x(w_out_x), .o_y(w_out_y), .o_last_px(w_out_last_px), .o_last_row(w_out_last_row)
  );

  always_comb begin
    w_rise         = r_vs_q & ~r_vs_q2;
    w_abort        = w_rise && (r_state != IDLE);
    // On an abort, the pixel of that cycle opens the new frame.
    w_accept       = bus.in_de && (w_abort || (!w_rise && ((r_state == FILL) || (r_state == RUN))));
    w_flush_wr     = !w_rise && (r_state == FLUSH);
    w_wr           = w_accept || w_flush_wr;
    w_wr_data      = w_flush_wr ? '0 : bus.in_data;
    // Only RUN and FLUSH writes are followed by a read. FILL writes only prime the buffer.
    w_arm          = w_flush_wr || (!w_rise && (r_state == RUN) && bus.in_de);
    w_drop         = bus.in_de && !w_accept;
    w_fill_to_run  = !w_rise && (r_state == FILL) && bus.in_de && w_in_last_px && (w_in_y == Y_FILL_LAST);
    w_run_to_flush = !w_rise && (r_state == RUN) && bus.in_de && w_in_last_px && w_in_last_row;
    w_flush_end    = w_flush_wr && w_in_last_px && (w_in_y == Y_FILL_LAST);
    w_done_pulse   = !w_rise && (r_state == DONE) && (r_done_cnt == 2'd2);
    w_in_inc       = (w_accept && !w_run_to_flush) || w_flush_wr;
    w_in_clr       = w_rise || w_run_to_flush;
    // The second clear, at the fill-to-run transition, discards counts made by
    // reads of an aborted frame that were still in flight.
    w_out_clr      = w_rise || w_fill_to_run;

    w_nxt = r_state;
    case (r_state)
      IDLE:    w_nxt = IDLE;
      FILL:    if (w_fill_to_run)  w_nxt = RUN;
      RUN:     if (w_run_to_flush) w_nxt = FLUSH;
      FLUSH:   if (w_flush_end)    w_nxt = DONE;
      DONE:    if (w_done_pulse)   w_nxt = IDLE;
      default: w_nxt = IDLE;
    endcase
    if (w_rise) w_nxt = FILL;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= IDLE;
      r_vs_q       <= 1'b0;
      r_vs_q2      <= 1'b0;
      r_done_cnt   <= 2'd0;
      r_lb_in_de   <= 1'b0;
      r_lb_in_data <= '0;
      r_rd_arm     <= 1'b0;
      r_lb_out_de  <= 1'b0;
      r_win_valid  <= 1'b0;
      r_win_x      <= '0;
      r_win_y      <= '0;
      r_win_left   <= 1'b0;
      r_win_right  <= 1'b0;
      r_win_top    <= 1'b0;
      r_win_bot    <= 1'b0;
      r_frame_done <= 1'b0;
      r_frame_err  <= 1'b0;
      r_drop       <= 1'b0;
    end else begin
      r_state      <= w_nxt;
      r_vs_q       <= bus.in_vsync;
      r_vs_q2      <= r_vs_q;
      r_done_cnt   <= (r_state == DONE) ? r_done_cnt + 2'd1 : 2'd0;
      r_lb_in_de   <= w_wr;
      r_lb_in_data <= w_wr ? w_wr_data : '0;
      r_rd_arm     <= w_arm;
      r_lb_out_de  <= r_lb_in_de & r_rd_arm;
      // The window stage lines up with the linebuffer's registered out_data.
      r_win_valid  <= r_lb_out_de;
      r_win_x      <= r_lb_out_de ? w_out_x : '0;
      r_win_y      <= r_lb_out_de ? w_out_y : '0;
      r_win_left   <= r_lb_out_de && (w_out_x == '0);
      r_win_right  <= r_lb_out_de && w_out_last_px;
      r_win_top    <= r_lb_out_de && (w_out_y < Y_TOP);
      r_win_bot    <= r_lb_out_de && (w_out_y > Y_BOT);
      r_frame_done <= w_done_pulse;
      r_frame_err  <= w_abort;
      r_drop       <= w_drop;
    end
  end

  assign bus.lb_in_de     = r_lb_in_de;
  assign bus.lb_in_data   = r_lb_in_data;
  assign bus.lb_out_de    = r_lb_out_de;
  assign bus.win_valid    = r_win_valid;
  assign bus.win_x        = r_win_x;
  assign bus.win_y        = r_win_y;
  assign bus.win_left     = r_win_left;
  assign bus.win_right    = r_win_right;
  assign bus.win_top      = r_win_top;
  assign bus.win_bot      = r_win_bot;
  assign bus.frame_done   = r_frame_done;
  assign bus.frame_err    = r_frame_err;
  assign bus.drop         = r_drop;
  assign bus.dbg_state    = r_state;
  assign bus.dbg_out_last = w_out_last_px & w_out_last_row;
endmodule
